// File: rtl/sobel_pkg.sv
// Shared types and window slot indices for the gray/Sobel pipeline.
package sobel_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 8;

    typedef logic [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t window_t [0:8];

    // Row-major slot numbering: TL is (r-2, c-2), BR is the current pixel.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-row delay line: tap_o is the sample shifted in DEPTH accepted strobes ago.
module sobel_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tap_o
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] mem_d [0:DEPTH-1];

    // Next contents: shift by one entry on each accepted sample
    always_comb begin
        mem_d = mem_q;
        if (shift_i) begin
            mem_d[0] = din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage with synchronous clear
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign tap_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 neighbourhood generator with two cascaded row delays.
// Optional per-frame window counter enabled by SOBEL_WIN_STATS_EN.
module sobel_window_buffer
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic                         px_rdy_i,
    input  logic [PIXEL_WIDTH-1:0]       in_pixel_i,
    output logic [9*PIXEL_WIDTH-1:0]     window_o,
    output logic                         window_vld_o,
    output logic                         frame_done_o,
    output logic [$clog2(IMG_WIDTH)-1:0] col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o
`ifdef SOBEL_WIN_STATS_EN
    ,
    output logic [15:0]                  win_count_o
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [PIXEL_WIDTH-1:0] lb1_tap_s;
    logic [PIXEL_WIDTH-1:0] lb2_tap_s;
    logic [CW-1:0]          cur_col_s;
    logic [RW-1:0]          cur_row_s;
    logic                   interior_s;

    logic [PIXEL_WIDTH-1:0] win_q [0:8];
    logic [PIXEL_WIDTH-1:0] win_d [0:8];
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   vld_q, vld_d;
    logic                   done_q, done_d;

    sobel_line_buffer #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH)
    ) u_lb1 (
        .clk_i   (clk_i),
        .clear_i (reset_i),
        .shift_i (px_rdy_i),
        .din_i   (in_pixel_i),
        .tap_o   (lb1_tap_s)
    );

    sobel_line_buffer #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH)
    ) u_lb2 (
        .clk_i   (clk_i),
        .clear_i (reset_i),
        .shift_i (px_rdy_i),
        .din_i   (lb1_tap_s),
        .tap_o   (lb2_tap_s)
    );

    // Position of the pixel being accepted; a start strobe makes it (0,0)
    always_comb begin
        cur_col_s = col_q;
        cur_row_s = row_q;
        if (start_i) begin
            cur_col_s = {CW{1'b0}};
            cur_row_s = {RW{1'b0}};
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
        interior_s = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    end

    // Window shift, position counters and output strobes
    always_comb begin
        win_d  = win_q;
        col_d  = col_q;
        row_d  = row_q;
        vld_d  = 1'b0;
        done_d = 1'b0;
        if (px_rdy_i) begin
            win_d[WIN_TL] = win_q[WIN_TC];
            win_d[WIN_TC] = win_q[WIN_TR];
            win_d[WIN_TR] = lb2_tap_s;
            win_d[WIN_ML] = win_q[WIN_MC];
            win_d[WIN_MC] = win_q[WIN_MR];
            win_d[WIN_MR] = lb1_tap_s;
            win_d[WIN_BL] = win_q[WIN_BC];
            win_d[WIN_BC] = win_q[WIN_BR];
            win_d[WIN_BR] = in_pixel_i;
            vld_d         = interior_s;
            if (cur_col_s == CW'(IMG_WIDTH - 1)) begin
                col_d = {CW{1'b0}};
                if (cur_row_s == RW'(IMG_HEIGHT - 1)) begin
                    row_d  = {RW{1'b0}};
                    done_d = 1'b1;
                end else begin
                    row_d = cur_row_s + RW'(1);
                end
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
        end else if (start_i) begin
            col_d = {CW{1'b0}};
            row_d = {RW{1'b0}};
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window and control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= {PIXEL_WIDTH{1'b0}};
            end
            col_q  <= {CW{1'b0}};
            row_q  <= {RW{1'b0}};
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            col_q  <= col_d;
            row_q  <= row_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    // Pack the window with slot k in bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]
    always_comb begin
        window_o = {(9*PIXEL_WIDTH){1'b0}};
        for (int k = 0; k < 9; k++) begin
            window_o[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[k];
        end
    end

    assign window_vld_o = vld_q;
    assign frame_done_o = done_q;
    assign col_o        = col_q;
    assign row_o        = row_q;

`ifdef SOBEL_WIN_STATS_EN
    logic [15:0] win_count_q, win_count_d;

    // Count windows per frame; the first pixel of a frame restarts the count
    always_comb begin
        win_count_d = win_count_q;
        if (px_rdy_i) begin
            if ((cur_row_s == RW'(0)) && (cur_col_s == CW'(0))) begin
                win_count_d = {15'd0, interior_s};
            end else if (interior_s && (win_count_q != 16'hFFFF)) begin
                win_count_d = win_count_q + 16'd1;
            end else begin
                win_count_d = win_count_q;
            end
        end else if (start_i) begin
            win_count_d = 16'd0;
        end else begin
            win_count_d = win_count_q;
        end
    end

    // Window counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            win_count_q <= 16'd0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign win_count_o = win_count_q;
`endif

endmodule
